matrix_print_ctrl: RTL
======================

Name: matrix_print_ctrl

Overview:
- Upstream sequencer for the matrix UART element sender.
- Walks a stored matrix in row-major order and reads each element from matrix storage.
- Hands each element to the sender with the correct last-column flag, waiting for the sender's done pulse between elements.
- Optionally requests one trailing blank line. Used by the display, generator and ALU result paths to print a whole matrix.

Parameters:
- MAX_ROWS, 5, largest legal row count.
- MAX_COLS, 5, largest legal column count; also the storage row stride.
- DATA_W, 8, signed element width; matches the package matrix_element_t.
- ADDR_W, 5, storage address width; must satisfy 2^ADDR_W >= MAX_ROWS*MAX_COLS.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  print request; sampled only in IDLE.
- rows  in  3  row count, 1..MAX_ROWS.
- cols  in  3  column count, 1..MAX_COLS.
- trail_nl  in  1  send an extra blank line after the matrix.
- abort  in  1  stop at the next element boundary.
- mem_rd_en  out  1  storage read strobe.
- mem_addr  out  ADDR_W  row*MAX_COLS+col.
- mem_rdata  in  DATA_W  storage data, valid the cycle after mem_rd_en.
- snd_start  out  1  one-cycle start pulse to the sender.
- snd_data  out  DATA_W  element value.
- snd_last_col  out  1  element is last in its row.
- snd_newline  out  1  newline-only request.
- snd_done  in  1  sender completion pulse.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse on illegal dimensions (coincides with done).

Behaviour:
- Reset: all outputs 0, state IDLE, row/col counters 0, abort_pend 0. Reset mid-print returns to IDLE next edge; an in-flight sender transfer is not tracked.
- Outputs are registered. snd_data, snd_last_col and snd_newline stay stable from snd_start until snd_done, because the sender samples them after its start pulse.
- On start in IDLE, rows and cols are latched.
  - rows==0, cols==0, rows>MAX_ROWS or cols>MAX_COLS: pulse err and done next cycle; no reads or sends; busy stays 0.
- States:
  - IDLE: accept start.
  - RD: mem_rd_en=1, mem_addr from counters.
  - LATCH: snd_data<=mem_rdata; snd_last_col<=(col==cols-1).
  - SEND: snd_start=1 for one cycle.
  - WAIT: hold until snd_done. Then:
    - abort_pend set: FINISH.
    - Otherwise advance col; on wrap, col<=0 and row++.
    - If the finished element was (rows-1, cols-1): go to TRAIL if trail_nl, else FINISH. Otherwise go to RD.
  - TRAIL: snd_newline=1, snd_start pulse.
  - WAIT_NL: wait for snd_done, then FINISH.
  - FINISH: done=1, busy<=0, clear snd_newline, go to IDLE.
- Latency: start at cycle N gives mem_rd_en at N+1, snd_data valid at N+3 and snd_start at N+3. snd_done at M gives the next mem_rd_en at M+1. done fires 1 cycle after the final snd_done.
- trail_nl is latched at start. A 1x1 matrix sends one element with snd_last_col=1.
- abort:
  - Any cycle while busy: abort_pend is set.
  - During SEND/WAIT: the current element completes first.
  - During TRAIL/WAIT_NL: the newline completes, then FINISH.
  - In IDLE: ignored.
- start while busy: ignored.
- snd_done outside WAIT/WAIT_NL: ignored.
- snd_done and abort in the same cycle: abort wins; go to FINISH.
- done is never asserted together with snd_start.

Decomposition:
- Shared package: matrix_element_t; MAX_ROWS and MAX_COLS constants; the print_state_t enum.
- Address generation and the row/col counter form a natural sub-module, matrix_addr_walker. Interface: clear, step, rows, cols, addr, last_col, last_elem.
- The sequencing FSM stays in matrix_print_ctrl.

Test Plan:
- 2x3 matrix with rows {1,-2,3},{40,-128,127}, trail_nl=0, sender model done 10 cycles after start → addresses 0,1,2,5,6,7 in order; snd_last_col high only for 3 and 127; exactly 6 snd_start; done 1 cycle after the 6th snd_done.
- 1x1 matrix with value -7, trail_nl=1 → one element with last_col=1, then one snd_newline request, then done; 2 snd_start total.
- rows=0, then cols=6 → err and done pulse 1 cycle after start; mem_rd_en and snd_start never assert.
- 5x5 matrix, abort asserted mid-way through element (2,1) → that element finishes, no further reads, done pulses, busy drops.
- start held high for 3 cycles plus an extra start mid-print on 3x3 → exactly 9 elements and one done; timing matches N+1/N+3 latency.
- rst asserted during WAIT on 3x3 → next cycle all outputs 0; a fresh start then prints all 9 elements from address 0.

Source files
------------

// File: rtl/matrix_print_ctrl_pkg.sv
// matrix_print_ctrl_pkg: types and constants shared by the matrix print sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: matrix element type, legal dimension limits, the print FSM state
// encoding and a helper that validates requested dimensions.
package matrix_print_ctrl_pkg;

    localparam int MAX_ROWS = 5;
    localparam int MAX_COLS = 5;
    localparam int ELEM_W   = 8;

    typedef logic signed [ELEM_W-1:0] matrix_element_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_LATCH   = 3'd2,
        ST_SEND    = 3'd3,
        ST_WAIT    = 3'd4,
        ST_TRAIL   = 3'd5,
        ST_WAIT_NL = 3'd6,
        ST_FINISH  = 3'd7
    } print_state_t;

    // A matrix is printable only if both dimensions are in 1..max.
    function automatic logic dims_ok(input logic [2:0] r, input logic [2:0] c,
                                     input int max_r, input int max_c);
        return (r != 3'd0) && (c != 3'd0) &&
               (int'(r) <= max_r) && (int'(c) <= max_c);
    endfunction

endpackage

// File: rtl/matrix_addr_walker.sv
// matrix_addr_walker: row-major row/col counter and storage address generator.
// Latency: address updates the cycle after clear/step.
// Backpressure: none; advances only when the sequencer pulses step.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clear         restart the walk at element (0,0)
//   step          advance to the next element in row-major order
//   rows, cols    latched matrix dimensions
//   addr          registered storage address row*MAX_COLS+col
//   last_col      current element is the last one of its row
//   last_elem     current element is (rows-1, cols-1)
module matrix_addr_walker #(
    parameter int MAX_COLS = 5,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              step,
    input  logic [2:0]        rows,
    input  logic [2:0]        cols,
    output logic [ADDR_W-1:0] addr,
    output logic              last_col,
    output logic              last_elem
);

    logic [2:0]        row;
    logic [2:0]        col;
    // Address of column 0 in the current row; kept incrementally so no
    // multiplier sits in the address path.
    logic [ADDR_W-1:0] row_base;

    assign last_col  = (col == cols - 3'd1);
    assign last_elem = last_col && (row == rows - 3'd1);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            row      <= 3'd0;
            col      <= 3'd0;
            row_base <= '0;
            addr     <= '0;
        end else if (step) begin
            if (last_col) begin
                // Wrap: storage stride is MAX_COLS regardless of cols.
                col      <= 3'd0;
                row      <= row + 3'd1;
                row_base <= row_base + ADDR_W'(MAX_COLS);
                addr     <= row_base + ADDR_W'(MAX_COLS);
            end else begin
                col  <= col + 3'd1;
                addr <= addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/matrix_print_ctrl.sv
// matrix_print_ctrl: walks a stored matrix row-major and feeds each element to the UART sender.
// Latency: start -> mem_rd_en +1, -> snd_start/snd_data +3; final snd_done -> done +1.
// Backpressure: one element in flight; the next read waits for the sender's snd_done.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, rows, cols,        print request with dimensions and optional
//   trail_nl                  trailing blank line (latched on accept)
//   abort                     stop at the next element boundary
//   mem_rd_en, mem_addr,      storage read port; mem_rdata is valid the
//   mem_rdata                 cycle after mem_rd_en
//   snd_start, snd_data,      sender request; payload held stable from
//   snd_last_col, snd_newline snd_start until snd_done
//   snd_done                  sender completion pulse
//   busy, done, err           status; err pulses with done on bad dims
module matrix_print_ctrl #(
    parameter int MAX_ROWS = 5,
    parameter int MAX_COLS = 5,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        rows,
    input  logic [2:0]        cols,
    input  logic              trail_nl,
    input  logic              abort,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              snd_start,
    output logic [DATA_W-1:0] snd_data,
    output logic              snd_last_col,
    output logic              snd_newline,
    input  logic              snd_done,
    output logic              busy,
    output logic              done,
    output logic              err
);

    import matrix_print_ctrl_pkg::*;

    print_state_t state;
    logic [2:0]   rows_q;
    logic [2:0]   cols_q;
    logic         trail_q;
    logic         abort_pend;

    logic         dims_bad;
    logic         abort_now;
    logic         walk_clear;
    logic         walk_step;
    logic         last_col;
    logic         last_elem;

    assign dims_bad  = !dims_ok(rows, cols, MAX_ROWS, MAX_COLS);
    // An abort arriving with snd_done must still win, so look at the raw
    // input as well as the pending flag.
    assign abort_now = abort_pend || abort;

    assign walk_clear = (state == ST_IDLE) && start && !dims_bad;
    assign walk_step  = (state == ST_WAIT) && snd_done && !abort_now && !last_elem;

    matrix_addr_walker #(
        .MAX_COLS (MAX_COLS),
        .ADDR_W   (ADDR_W)
    ) u_walker (
        .clk       (clk),
        .rst       (rst),
        .clear     (walk_clear),
        .step      (walk_step),
        .rows      (rows_q),
        .cols      (cols_q),
        .addr      (mem_addr),
        .last_col  (last_col),
        .last_elem (last_elem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            rows_q       <= 3'd0;
            cols_q       <= 3'd0;
            trail_q      <= 1'b0;
            abort_pend   <= 1'b0;
            mem_rd_en    <= 1'b0;
            snd_start    <= 1'b0;
            snd_data     <= '0;
            snd_last_col <= 1'b0;
            snd_newline  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            // Remember an abort seen anywhere in the print; acted on only
            // once the element or newline in flight has completed.
            if (busy && abort) begin
                abort_pend <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (dims_bad) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= ST_FINISH;
                        end else begin
                            rows_q    <= rows;
                            cols_q    <= cols;
                            trail_q   <= trail_nl;
                            busy      <= 1'b1;
                            mem_rd_en <= 1'b1;
                            state     <= ST_RD;
                        end
                    end
                end

                ST_RD: begin
                    mem_rd_en <= 1'b0;
                    state     <= ST_LATCH;
                end

                ST_LATCH: begin
                    // Storage data is valid now, one cycle after the strobe.
                    snd_data     <= mem_rdata;
                    snd_last_col <= last_col;
                    snd_newline  <= 1'b0;
                    snd_start    <= 1'b1;
                    state        <= ST_SEND;
                end

                ST_SEND: begin
                    snd_start <= 1'b0;
                    state     <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (snd_done) begin
                        if (abort_now || (last_elem && !trail_q)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_FINISH;
                        end else if (last_elem) begin
                            snd_newline <= 1'b1;
                            snd_start   <= 1'b1;
                            state       <= ST_TRAIL;
                        end else begin
                            mem_rd_en <= 1'b1;
                            state     <= ST_RD;
                        end
                    end
                end

                ST_TRAIL: begin
                    snd_start <= 1'b0;
                    state     <= ST_WAIT_NL;
                end

                ST_WAIT_NL: begin
                    if (snd_done) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_FINISH;
                    end
                end

                ST_FINISH: begin
                    done        <= 1'b0;
                    err         <= 1'b0;
                    snd_newline <= 1'b0;
                    abort_pend  <= 1'b0;
                    state       <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
